// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU codes and FSM states.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALUOP_IDLE yields an all-zero alucontrol in states that do not use the ALU.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IDLE  = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to an ALU operation.
module aludec
  import mips_defs::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = '0;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUCTL_ADD;
      ALUOP_SUB: alucontrol = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALUCTL_ADD;
          FUNCT_SUB: alucontrol = ALUCTL_SUB;
          FUNCT_AND: alucontrol = ALUCTL_AND;
          FUNCT_OR:  alucontrol = ALUCTL_OR;
          FUNCT_SLT: alucontrol = ALUCTL_SLT;
          default: begin
            alucontrol    = ALUCTL_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alucontrol = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore main controller for the multicycle MIPS datapath; produces all mux selects and write enables.
module mips_multicycle_controller
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t state, state_next, cur;
  aluop_t aluop;
  logic   pcwrite, branch, funct_illegal;
  logic   memwrite_s, irwrite_s, regwrite_s, illegal_s;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Outputs decode as FETCH while reset is high; enables are masked below.
  assign cur = reset ? S_FETCH : state;

  aludec u_aludec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_next = S_FETCH;
    aluop      = ALUOP_IDLE;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    illegal_s  = 1'b0;
    case (cur)
      S_FETCH: begin
        alusrcb    = SRCB_FOUR;
        aluop      = ALUOP_ADD;
        irwrite_s  = 1'b1;
        pcwrite    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM2;
        aluop   = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal_s  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_ADD;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        illegal_s  = funct_illegal;
        state_next = funct_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_ADD;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign memwrite = ~reset & memwrite_s;
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Table-driven cycle-by-cycle check of the multicycle MIPS controller outputs.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  mips_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  logic [15:0] got;
  assign got = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [15:0] E_RST  = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_FET  = {8'b1001_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_DEC  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_DECI = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [15:0] E_MADR = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MRD  = {8'b0100_0000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [15:0] E_MWB  = {8'b0000_0110, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [15:0] E_MWR  = {8'b0110_0000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [15:0] E_AWB  = {8'b0000_1010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [15:0] E_AIWB = {8'b0000_0010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [15:0] E_JMP  = {8'b1000_0000, 2'b00, 2'b10, 3'b000, 1'b0};
  localparam logic [15:0] E_BR0  = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [15:0] E_BR1  = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0};

  function automatic logic [15:0] e_exec(input logic [2:0] alu, input logic ill);
    return {8'b0000_0001, 2'b00, 2'b00, alu, ill};
  endfunction

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [15:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, req);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int mw_cnt, rw_cnt;
    // reset held two cycles, then lw
    add(1, 6'b100011, 6'b0, 0, E_RST);
    add(1, 6'b100011, 6'b0, 0, E_RST);
    add(0, 6'b100011, 6'b0, 0, E_FET);
    add(0, 6'b100011, 6'b0, 0, E_DEC);
    add(0, 6'b100011, 6'b0, 0, E_MADR);
    add(0, 6'b100011, 6'b0, 0, E_MRD);
    add(0, 6'b100011, 6'b0, 0, E_MWB);
    // R-type sub
    add(0, 6'b000000, 6'b100010, 0, E_FET);
    add(0, 6'b000000, 6'b100010, 0, E_DEC);
    add(0, 6'b000000, 6'b100010, 0, e_exec(3'b110, 0));
    add(0, 6'b000000, 6'b100010, 0, E_AWB);
    // beq taken, then not taken
    add(0, 6'b000100, 6'b0, 1, E_FET);
    add(0, 6'b000100, 6'b0, 1, E_DEC);
    add(0, 6'b000100, 6'b0, 1, E_BR1);
    add(0, 6'b000100, 6'b0, 0, E_FET);
    add(0, 6'b000100, 6'b0, 0, E_DEC);
    add(0, 6'b000100, 6'b0, 0, E_BR0);
    // sw
    add(0, 6'b101011, 6'b0, 0, E_FET);
    add(0, 6'b101011, 6'b0, 0, E_DEC);
    add(0, 6'b101011, 6'b0, 0, E_MADR);
    add(0, 6'b101011, 6'b0, 0, E_MWR);
    // illegal opcode, then illegal funct
    add(0, 6'b111111, 6'b0, 0, E_FET);
    add(0, 6'b111111, 6'b0, 0, E_DECI);
    add(0, 6'b000000, 6'b000111, 0, E_FET);
    add(0, 6'b000000, 6'b000111, 0, E_DEC);
    add(0, 6'b000000, 6'b000111, 0, e_exec(3'b010, 1));
    // addi
    add(0, 6'b001000, 6'b0, 0, E_FET);
    add(0, 6'b001000, 6'b0, 0, E_DEC);
    add(0, 6'b001000, 6'b0, 0, E_MADR);
    add(0, 6'b001000, 6'b0, 0, E_AIWB);
    // j
    add(0, 6'b000010, 6'b0, 0, E_FET);
    add(0, 6'b000010, 6'b0, 0, E_DEC);
    add(0, 6'b000010, 6'b0, 0, E_JMP);
    // sw interrupted by reset in MEMWR
    add(0, 6'b101011, 6'b0, 0, E_FET);
    add(0, 6'b101011, 6'b0, 0, E_DEC);
    add(0, 6'b101011, 6'b0, 0, E_MADR);
    add(1, 6'b101011, 6'b0, 0, E_RST);
    // R-type add interrupted by reset in ALUWB
    add(0, 6'b000000, 6'b100000, 0, E_FET);
    add(0, 6'b000000, 6'b100000, 0, E_DEC);
    add(0, 6'b000000, 6'b100000, 0, e_exec(3'b010, 0));
    add(1, 6'b000000, 6'b100000, 0, E_RST);
    // or, slt, and
    add(0, 6'b000000, 6'b100101, 0, E_FET);
    add(0, 6'b000000, 6'b100101, 0, E_DEC);
    add(0, 6'b000000, 6'b100101, 0, e_exec(3'b001, 0));
    add(0, 6'b000000, 6'b100101, 0, E_AWB);
    add(0, 6'b000000, 6'b101010, 0, E_FET);
    add(0, 6'b000000, 6'b101010, 0, E_DEC);
    add(0, 6'b000000, 6'b101010, 0, e_exec(3'b111, 0));
    add(0, 6'b000000, 6'b101010, 0, E_AWB);
    add(0, 6'b000000, 6'b100100, 0, E_FET);
    add(0, 6'b000000, 6'b100100, 0, E_DEC);
    add(0, 6'b000000, 6'b100100, 0, e_exec(3'b000, 0));
    add(0, 6'b000000, 6'b100100, 0, E_AWB);
    add(0, 6'b000100, 6'b0, 0, E_FET);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
      #1;
      check($sformatf("vec[%0d]", i), got, vecs[i].exp);
    end

    // beq in flight: pcen must follow zero combinationally within BRANCH
    @(negedge clk); op = 6'b000100; zero = 1'b0; #1;
    check("beq_decode", got, E_DEC);
    @(negedge clk); zero = 1'b0; #1;
    check_bit("branch_pcen_z0", pcen, 1'b0);
    zero = 1'b1; #1;
    check_bit("branch_pcen_z1", pcen, 1'b1);
    check("branch_outputs_z1", got, E_BR1);
    @(negedge clk); zero = 1'b0; op = 6'b101011; #1;
    check("beq_back_to_fetch", got, E_FET);

    // full sw: exactly one memwrite cycle, never regwrite
    mw_cnt = 0; rw_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) begin
        @(negedge clk); #1;
      end
      mw_cnt += int'(memwrite);
      rw_cnt += int'(regwrite);
    end
    @(negedge clk); #1;
    check_bit("sw_memwrite_once", mw_cnt == 1, 1'b1);
    check_bit("sw_no_regwrite", rw_cnt == 0, 1'b1);
    check("sw_back_to_fetch", got, E_FET);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Main control unit for the multicycle MIPS datapath. It is the initiator side of the ALU interface: it drives alucontrol each cycle and consumes the ALU zero flag. A Moore FSM sequences fetch, decode, execute, memory and writeback steps. It also produces every datapath mux select and write enable.

Parameters:
None. Opcode, funct and state encodings are fixed constants in the shared package.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag for the current cycle's ALU operation
pcen  out  1  PC register write enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  data memory write strobe
irwrite  out  1  instruction register load
regdst  out  1  register write address select: 0 = rt, 1 = rd
memtoreg  out  1  register write data select: 0 = ALUOut, 1 = memory data
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  out  1  one-cycle pulse on an unsupported op or funct

Behaviour:
- State register is 4 bits.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- reset sampled high at a clock edge: state <= FETCH.
- While reset is high, pcen, irwrite, memwrite, regwrite and illegal are forced to 0. All other outputs decode as FETCH.
- Outputs are Moore (a function of state and the IR fields) except pcen, which is pcwrite | (branch & zero) and is combinational on zero.
- Unlisted outputs are 0 in every state.
- Per-state outputs and next state:
  - FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=0, alusrcb=11, alucontrol=add (computes the branch target into ALUOut).
    - op 100011 (lw) or 101011 (sw) -> MEMADR
    - op 000000 -> EXEC
    - op 000100 (beq) -> BRANCH
    - op 001000 (addi) -> ADDIEX
    - op 000010 (j) -> JUMP
    - any other op -> FETCH, with illegal=1 this cycle
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=add. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR: iord=1, memwrite=1. Next: FETCH.
  - EXEC: alusrca=1, alusrcb=00, alucontrol from funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt -> ALUWB
    - any other funct: alucontrol=add, illegal=1, next FETCH (no writeback)
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - BRANCH: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, branch=1. pcen=zero. Next: FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, alucontrol=add. Next: ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- op and funct are sampled only in DECODE, MEMADR and EXEC. The IR is stable after FETCH, so no extra latching is needed.
- Reset asserted mid-instruction (e.g. in MEMWR): no write enable is asserted that cycle. Next state is FETCH. No partial writeback.
- Unreachable state encodings: all enables 0, next state FETCH.

Decomposition:
- Shared package mips_defs:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - 3-bit ALUCTL_* codes
  - 2-bit aluop codes (00 add, 01 sub, 10 funct)
  - 4-bit state encodings
- Sub-module aludec: a combinational map from (aluop, funct) to (alucontrol, funct_illegal). The FSM drives aluop; aludec drives alucontrol.

Test Plan:
- Reset held 2 cycles, then released with op=100011 (lw): states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. irwrite=1 only in FETCH. regwrite=1 and memtoreg=1 only in MEMWB.
- R-type op=0, funct=100010: alucontrol=110 in EXEC. regwrite=1 and regdst=1 in ALUWB. 4-cycle instruction.
- beq, drive zero=1 in BRANCH: pcen=1 and pcsrc=01. Repeat with zero=0: pcen=0. Both return to FETCH after 3 cycles.
- sw op=101011: memwrite=1 and iord=1 for exactly one cycle (MEMWR). regwrite stays 0 throughout.
- op=111111: illegal=1 in DECODE, return to FETCH. Then R-type with funct=000111: illegal=1 in EXEC, and regwrite never asserts.
- Assert reset during MEMWR and during ALUWB: memwrite=0 and regwrite=0 that cycle. State is FETCH on the following cycle.
